// File: rtl/eriscv_timer.sv
// rtl/eriscv_timer.sv - memory-mapped 64-bit machine timer on the Eriscv data bus
// Optional prescaler is built when TIMER_PRESCALE_EN is defined.
module eriscv_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq
);

  localparam logic [2:0] R_CTRL     = 3'd0;
  localparam logic [2:0] R_STATUS   = 3'd1;
  localparam logic [2:0] R_MTIME_LO = 3'd2;
  localparam logic [2:0] R_MTIME_HI = 3'd3;
  localparam logic [2:0] R_CMP_LO   = 3'd4;
  localparam logic [2:0] R_CMP_HI   = 3'd5;

  logic        en, irq_en, auto_reload, match;
  logic [63:0] mtime, mtimecmp, mtime_nxt;
  logic [31:0] shadow_hi;
  logic [7:0]  presc_val;
  logic [2:0]  idx;
  logic        hit, wr, rd, tick, mtime_wr, reload_evt, match_set;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  assign hit = ce && (addr[31:5] == BASE_ADDR[31:5]);
  assign wr  = hit && we;
  assign rd  = hit && !we;
  assign idx = addr[4:2];
  assign unused_addr_bits = ^addr[1:0];

`ifdef TIMER_PRESCALE_EN
  logic [7:0] presc, pcnt;
  logic       presc_wr;

  assign presc_wr  = wr && (idx == R_CTRL) && sel[1];
  assign presc_val = presc;
  assign tick      = en && (pcnt == presc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= 8'd0;
      pcnt  <= 8'd0;
    end else begin
      if (presc_wr) presc <= data_i[15:8];
      if (!en || presc_wr || tick) pcnt <= 8'd0;
      else                         pcnt <= pcnt + 8'd1;
    end
  end
`else
  assign presc_val = 8'd0;
  assign tick      = en;
`endif

  // A bus write to either half of mtime suppresses that cycle's tick entirely.
  assign mtime_wr   = wr && ((idx == R_MTIME_LO) || (idx == R_MTIME_HI));
  assign reload_evt = tick && auto_reload && (mtime == mtimecmp) && !mtime_wr;
  assign match_set  = (mtime >= mtimecmp) || reload_evt;

  always_comb begin
    mtime_nxt = mtime;
    if (wr && (idx == R_MTIME_LO))      mtime_nxt[31:0]  = merge(mtime[31:0], data_i, sel);
    else if (wr && (idx == R_MTIME_HI)) mtime_nxt[63:32] = merge(mtime[63:32], data_i, sel);
    else if (reload_evt)                mtime_nxt = 64'd0;
    else if (tick)                      mtime_nxt = mtime + 64'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en          <= 1'b0;
      irq_en      <= 1'b0;
      auto_reload <= 1'b0;
      match       <= 1'b0;
      mtime       <= 64'd0;
      mtimecmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_hi   <= 32'd0;
    end else begin
      mtime <= mtime_nxt;
      if (wr && (idx == R_CTRL) && sel[0]) begin
        en          <= data_i[0];
        irq_en      <= data_i[1];
        auto_reload <= data_i[2];
      end
      // Set has priority over a simultaneous write-1-to-clear.
      if (match_set)                                        match <= 1'b1;
      else if (wr && (idx == R_STATUS) && sel[0] && data_i[0]) match <= 1'b0;
      if (wr && (idx == R_CMP_LO)) mtimecmp[31:0]  <= merge(mtimecmp[31:0], data_i, sel);
      if (wr && (idx == R_CMP_HI)) mtimecmp[63:32] <= merge(mtimecmp[63:32], data_i, sel);
      if (rd && (idx == R_MTIME_LO)) shadow_hi <= mtime[63:32];
    end
  end

  always_comb begin
    data_o = 32'd0;
    if (rd) begin
      case (idx)
        R_CTRL:     data_o = {16'd0, presc_val, 5'd0, auto_reload, irq_en, en};
        R_STATUS:   data_o = {31'd0, match};
        R_MTIME_LO: data_o = mtime[31:0];
        R_MTIME_HI: data_o = shadow_hi;
        R_CMP_LO:   data_o = mtimecmp[31:0];
        R_CMP_HI:   data_o = mtimecmp[63:32];
        default:    data_o = 32'd0;
      endcase
    end
  end

  assign irq = match & irq_en;

endmodule

// File: tb/tb_eriscv_timer.sv
// tb/tb_eriscv_timer.sv - scoreboard bench for eriscv_timer (build with or without TIMER_PRESCALE_EN)
module tb_eriscv_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        irq;
  logic        irq_probe = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_irq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  eriscv_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  // Monitor: pops the scoreboard whenever a read or irq probe is presented.
  always @(negedge clk) begin
    if ((ce && !we) || irq_probe) begin
      exp_t        t;
      logic [31:0] act;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: DUT access with no expected value queued");
      end else begin
        t   = sb.pop_front();
        act = t.is_irq ? {31'd0, irq} : data_o;
        if (act !== t.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", t.name, act, t.exp);
        end
      end
    end
  end

  task automatic wr32(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s);
    ce = 1'b1; we = 1'b1; addr = BASE + {27'd0, off}; sel = s; data_i = d;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd_abs(input string nm, input logic [31:0] a, input logic [31:0] e);
    sb.push_back(exp_t'{nm, e, 1'b0});
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic rd32(input string nm, input logic [4:0] off, input logic [31:0] e);
    rd_abs(nm, BASE + {27'd0, off}, e);
  endtask

  task automatic chk_irq(input string nm, input logic e);
    sb.push_back(exp_t'{nm, {31'd0, e}, 1'b1});
    irq_probe = 1'b1;
    @(posedge clk); #1;
    irq_probe = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stop_clear();
    wr32(5'h00, 32'd0, 4'hF);
    wr32(5'h08, 32'd0, 4'hF);
    wr32(5'h0C, 32'd0, 4'hF);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset values
    rd32("rst_cmp_lo", 5'h10, 32'hFFFF_FFFF);
    rd32("rst_cmp_hi", 5'h14, 32'hFFFF_FFFF);
    rd32("rst_ctrl", 5'h00, 32'd0);
    rd32("rst_mtime_lo", 5'h08, 32'd0);
    rd32("rst_status", 5'h04, 32'd0);
    chk_irq("rst_irq", 1'b0);
    rd32("reserved_18", 5'h18, 32'd0);
    rd_abs("miss_addr", 32'h5000_0008, 32'd0);

    // Basic count, PRESC=0: tick every cycle from the edge after the enable write
    wr32(5'h00, 32'h1, 4'hF);
    wait_cycles(10);
    rd32("count_10", 5'h08, 32'd10);
    wr32(5'h08, 32'd100, 4'hF);
    rd32("write_wins_over_tick", 5'h08, 32'd100);
    rd32("count_after_write", 5'h08, 32'd101);

    // Prescaler
    stop_clear();
    wr32(5'h00, 32'h301, 4'hF);
`ifdef TIMER_PRESCALE_EN
    rd32("ctrl_presc", 5'h00, 32'h301);
    wait_cycles(39);
    rd32("presc_count", 5'h08, 32'd10);
`else
    rd32("ctrl_no_presc", 5'h00, 32'h1);
    wait_cycles(9);
    rd32("no_presc_count", 5'h08, 32'd10);
`endif

    // Byte-enable write
    stop_clear();
    wr32(5'h10, 32'd0, 4'hF);
    wr32(5'h10, 32'hAABB_CCDD, 4'b0010);
    rd32("byte_write_lo", 5'h10, 32'h0000_CC00);
    rd32("byte_write_hi_kept", 5'h14, 32'hFFFF_FFFF);

    // Interrupt latency, set-over-clear, IRQ_EN gating
    stop_clear();
    wr32(5'h10, 32'd5, 4'hF);
    wr32(5'h14, 32'd0, 4'hF);
    wr32(5'h04, 32'd1, 4'hF);
    rd32("status_clear_before_irq", 5'h04, 32'd0);
    wr32(5'h00, 32'h3, 4'hF);
    wait_cycles(5);
    chk_irq("irq_low_at_mtime5", 1'b0);
    chk_irq("irq_high_after", 1'b1);
    rd32("status_match", 5'h04, 32'd1);
    wr32(5'h04, 32'd1, 4'hF);
    rd32("w1c_set_wins", 5'h04, 32'd1);
    wr32(5'h00, 32'h1, 4'hF);
    chk_irq("irq_masked", 1'b0);
    wr32(5'h00, 32'h3, 4'hF);
    chk_irq("irq_unmasked", 1'b1);
    wr32(5'h10, 32'd1000, 4'hF);
    wr32(5'h04, 32'd1, 4'hF);
    rd32("status_cleared", 5'h04, 32'd0);
    chk_irq("irq_cleared", 1'b0);

    // High-word snapshot across the 32-bit carry
    stop_clear();
    wr32(5'h08, 32'hFFFF_FFFE, 4'hF);
    wr32(5'h00, 32'h1, 4'hF);
    rd32("snap_lo", 5'h08, 32'hFFFF_FFFE);
    wait_cycles(2);
    rd32("snap_hi_old", 5'h0C, 32'd0);
    rd32("snap_lo2", 5'h08, 32'd2);
    rd32("snap_hi_new", 5'h0C, 32'd1);

    // Auto-reload
    stop_clear();
    wr32(5'h10, 32'd3, 4'hF);
    wr32(5'h04, 32'd1, 4'hF);
    rd32("ar_status_clear", 5'h04, 32'd0);
    wr32(5'h00, 32'h5, 4'hF);
    rd32("ar_seq0", 5'h08, 32'd0);
    rd32("ar_seq1", 5'h08, 32'd1);
    rd32("ar_seq2", 5'h08, 32'd2);
    rd32("ar_seq3", 5'h08, 32'd3);
    rd32("ar_seq_reload", 5'h08, 32'd0);
    rd32("ar_match", 5'h04, 32'd1);
    wr32(5'h00, 32'h7, 4'hF);
    chk_irq("ar_irq", 1'b1);

    // Reset asserted in the middle of a write aborts it
    ce = 1'b1; we = 1'b1; addr = BASE + 32'h10; sel = 4'hF; data_i = 32'h1234_5678;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    rd32("mid_rst_ctrl", 5'h00, 32'd0);
    rd32("mid_rst_cmp_lo", 5'h10, 32'hFFFF_FFFF);
    rd32("mid_rst_mtime", 5'h08, 32'd0);
    rd32("mid_rst_status", 5'h04, 32'd0);
    chk_irq("mid_rst_irq", 1'b0);

    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eriscv_timer.md
# eriscv_timer

Memory-mapped machine timer that answers the Eriscv data-memory bus (ce/we/addr/sel/data), alongside the data RAM in the SOPC. It keeps a 64-bit free-running `mtime` with an optional prescaler and a 64-bit `mtimecmp`. It raises a level interrupt on a compare match and offers tear-free 64-bit reads through a high-word snapshot. Reads are zero-wait and writes commit on the clock edge, the same access timing as the data RAM, so the core needs no changes.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: byte base of the 32-byte register window. Bits [4:0] must be 0.
- `clk  input  1`: system clock, rising-edge active.
- `rst  input  1`: asynchronous, active-low reset (asserted when 0, released synchronously by the SOPC).
- `ce  input  1`: bus access strobe from the core (`ram_ce_o`).
- `we  input  1`: 1 = write, 0 = read (`ram_we_o`).
- `addr  input  32`: byte address (`ram_addr_o`).
- `sel  input  4`: byte enables. `sel[i]` covers bits [8i+7:8i].
- `data_i  input  32`: write data (`ram_data_o`).
- `data_o  output  32`: read data, muxed into `ram_data_i` by the SOPC.
- `irq  output  1`: timer interrupt, level, active-high.

## Operation
- Hit: `ce && addr[31:5] == BASE_ADDR[31:5]`. The register is selected by `addr[4:2]`. `addr[1:0]` is ignored.
- Register map by byte offset:
  - 0x00 CTRL: [0] EN, [1] IRQ_EN, [2] AUTO_RELOAD, [15:8] PRESC. All other bits read 0.
  - 0x04 STATUS: [0] MATCH. Writing 1 clears it (W1C); writing 0 has no effect.
  - 0x08 MTIME_LO. 0x0C MTIME_HI.
  - 0x10 MTIMECMP_LO. 0x14 MTIMECMP_HI.
  - 0x18 and 0x1C: read 0, writes ignored.
- Writes commit at the rising edge, per enabled byte. Bytes with `sel[i]=0` hold their value.
- Prescaler: an 8-bit `pcnt` runs only while EN=1.
  - A tick occurs when `pcnt == PRESC`. `pcnt` then returns to 0; otherwise it increments.
  - PRESC=0 gives one tick per cycle. EN=0 holds `pcnt` at 0.
- Counter update on a tick:
  - AUTO_RELOAD=1 and `mtime == mtimecmp`: `mtime` goes to 0.
  - Otherwise: `mtime` increments by 1 and wraps 2^64−1 → 0.
- Match: each cycle, MATCH is set if `mtime >= mtimecmp` (unsigned 64-bit). It is also set on an auto-reload event.
- `irq = MATCH & IRQ_EN`.
- Snapshot: a read hit on MTIME_LO latches `mtime[63:32]` into `shadow_hi` at that edge. Reads of MTIME_HI return `shadow_hi`, not the live value.
- Simultaneous events:
  - A bus write to MTIME_LO or MTIME_HI in a tick cycle: the write wins, and no half of `mtime` increments that cycle.
  - A W1C on MATCH in a cycle where the set condition holds: set wins.
  - Writing CTRL.PRESC resets `pcnt` to 0.
- Reset (async, `rst`=0): CTRL=0, MATCH=0, `mtime`=0, `pcnt`=0, `shadow_hi`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF. Outputs `irq`=0 and `data_o`=0.
- Reset asserted mid-access aborts the write, and all state returns to its reset values immediately.

## Timing
- Read: `data_o` is combinational from `ce/we/addr`, valid in the same cycle. `data_o`=0 when there is no read hit.
- Write: visible to reads from the next cycle.
- Tick-to-MATCH: `mtime` reaches `mtimecmp` at edge N, MATCH is 1 after edge N+1, and `irq` follows combinationally.
- No wait states and no back-pressure. Every access completes in one cycle.

## Configuration
- `TIMER_PRESCALE_EN` defined: the prescaler is present and behaves as described above.
- Not defined: `pcnt` is removed and a tick occurs on every cycle while EN=1. CTRL[15:8] reads 0 and writes to it are ignored.

## Test plan
- Reset check: after reset, read 0x10/0x14 → 32'hFFFF_FFFF each. Read 0x00/0x08 → 0. `irq`=0.
- Basic count: write CTRL=32'h0000_0001 (EN, PRESC=0), then wait 10 cycles and read MTIME_LO → 10 ±1, consistent with the write-to-enable latency.
- Prescale (macro defined): CTRL=32'h0000_0301 (PRESC=3). After 40 cycles, MTIME_LO = 10.
- Byte write: MTIMECMP_LO=0, then write 32'hAABB_CCDD with sel=4'b0010 → reads 32'h0000_CC00.
- Interrupt: mtimecmp=5, CTRL=32'h3. Expect `irq` to rise one cycle after `mtime`=5. W1C of STATUS with `mtime`≥5 → MATCH stays 1. Then set mtimecmp=1000 and W1C → `irq`=0.
- Snapshot and auto-reload:
  - Preload `mtime`=32'hFFFF_FFFE in LO, EN=1. Read LO then HI three cycles later → HI=0 (the snapshot value, not the live 1).
  - With AUTO_RELOAD=1 and mtimecmp=3: `mtime` sequence 0,1,2,3,0 and MATCH=1.
